// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the core and the front-panel host
// sequencer (LOAD / CLEAR / SCAN); the core is stalled while a host operation runs.
module dmem_port_arbiter #(
    parameter logic [31:0] OPA_ADDR  = 32'h0000_0000,
    parameter logic [31:0] OPB_ADDR  = 32'h0000_0004,
    parameter logic [31:0] RES_BASE  = 32'h0000_0008,
    parameter int unsigned RES_COUNT = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_req,
    input  logic        clear_req,
    input  logic        scan_req,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        cpu_we,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    output logic        cpu_stall,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        res_valid,
    output logic [2:0]  res_idx,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_A,
        S_CLR_B,
        S_LD_A,
        S_LD_B,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_pend_clr;
    logic               r_pend_load;
    logic               r_pend_scan;
    logic [DATA_W-1:0]  r_op_a;
    logic [DATA_W-1:0]  r_op_b;
    logic [IDX_W-1:0]   r_idx;
    logic               r_res_valid;
    logic [IDX_W-1:0]   r_res_idx;
    logic [DATA_W-1:0]  r_res_data;

    logic               w_idle;
    logic               w_want_clr;
    logic               w_want_load;
    logic               w_want_scan;
    logic               w_grant_clr;
    logic               w_grant_load;
    logic               w_grant_scan;
    logic               w_last_idx;
    logic               w_mem_we;
    logic [DATA_W-1:0]  w_mem_a;
    logic [DATA_W-1:0]  w_mem_wd;

    // A request in the same cycle counts as pending; grants only happen from IDLE.
    assign w_idle       = (r_state == S_IDLE);
    assign w_want_clr   = r_pend_clr  | clear_req;
    assign w_want_load  = r_pend_load | load_req;
    assign w_want_scan  = r_pend_scan | scan_req;
    assign w_grant_clr  = w_idle & w_want_clr;
    assign w_grant_load = w_idle & ~w_want_clr & w_want_load;
    assign w_grant_scan = w_idle & ~w_want_clr & ~w_want_load & w_want_scan;
    assign w_last_idx   = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pend_clr  <= 1'b0;
            r_pend_load <= 1'b0;
            r_pend_scan <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_idx       <= '0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_data  <= '0;
        end else begin
            r_pend_clr  <= w_want_clr  & ~w_grant_clr;
            r_pend_load <= w_want_load & ~w_grant_load;
            r_pend_scan <= w_want_scan & ~w_grant_scan;
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_clr) begin
                        r_state <= S_CLR_A;
                    end else if (w_grant_load) begin
                        r_state <= S_LD_A;
                        r_op_a  <= op_a;
                        r_op_b  <= op_b;
                    end else if (w_grant_scan) begin
                        r_state <= S_SCAN;
                    end
                end
                S_CLR_A: r_state <= S_CLR_B;
                S_CLR_B: r_state <= S_DONE;
                S_LD_A:  r_state <= S_LD_B;
                S_LD_B:  r_state <= S_DONE;
                S_SCAN: begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= mem_rd;
                    r_res_idx   <= r_idx;
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory port mux: pass-through in IDLE, host sequencer otherwise.
    always_comb begin
        w_mem_we = 1'b0;
        w_mem_a  = cpu_a;
        w_mem_wd = cpu_wd;
        case (r_state)
            S_IDLE: w_mem_we = cpu_we;
            S_CLR_A: begin
                w_mem_we = 1'b1;
                w_mem_a  = OPA_ADDR;
                w_mem_wd = '0;
            end
            S_CLR_B: begin
                w_mem_we = 1'b1;
                w_mem_a  = OPB_ADDR;
                w_mem_wd = '0;
            end
            S_LD_A: begin
                w_mem_we = 1'b1;
                w_mem_a  = OPA_ADDR;
                w_mem_wd = r_op_a;
            end
            S_LD_B: begin
                w_mem_we = 1'b1;
                w_mem_a  = OPB_ADDR;
                w_mem_wd = r_op_b;
            end
            S_SCAN: w_mem_a = RES_BASE + DATA_W'({r_idx, 2'b00});
            default: w_mem_we = 1'b0;
        endcase
    end

    // Reset must block memory writes and release the core even before the clock runs.
    assign mem_we    = reset_n & w_mem_we;
    assign mem_a     = w_mem_a;
    assign mem_wd    = w_mem_wd;
    assign cpu_stall = reset_n & ~w_idle;
    assign cpu_rd    = mem_rd;
    assign busy      = ~w_idle;
    assign done      = (r_state == S_DONE);
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: small data-memory model behind the port, scoreboard
// queues of expected memory writes and scan results.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        load_req;
    logic        clear_req;
    logic        scan_req;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        cpu_we;
    logic [31:0] cpu_a;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        res_valid;
    logic [2:0]  res_idx;
    logic [31:0] res_data;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    logic [31:0] mem [0:7];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [2:0]  exp_idx[$];
    logic [31:0] exp_rd[$];

    dmem_port_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_req  (load_req),
        .clear_req (clear_req),
        .scan_req  (scan_req),
        .op_a      (op_a),
        .op_b      (op_b),
        .cpu_we    (cpu_we),
        .cpu_a     (cpu_a),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_stall (cpu_stall),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_a[4:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_a[4:2]];

    task automatic push_scan_results();
        logic [31:0] vals [0:4];
        vals[0] = 32'd15; vals[1] = 32'd5; vals[2] = 32'd50; vals[3] = 32'd2; vals[4] = 32'd100;
        for (int i = 0; i < 5; i++) begin
            exp_idx.push_back(3'(i));
            exp_rd.push_back(vals[i]);
        end
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
        cpu_a  = addr;
        cpu_wd = data;
        cpu_we = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_req = 1'b0; clear_req = 1'b0; scan_req = 1'b0;
        op_a = '0; op_b = '0;
        cpu_we = 1'b1; cpu_a = 32'h20; cpu_wd = 32'hAB;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_we, cpu_stall, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl: we=%b stall=%b busy=%b done=%b want all 0", mem_we, cpu_stall, busy, done);
        end
        checks++;
        if ({res_valid, res_idx, res_data} !== 36'd0) begin
            failures++;
            $display("FAIL reset_res: valid=%b idx=%0d data=%h want 0", res_valid, res_idx, res_data);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_a, mem_wd, cpu_stall, busy} !== {1'b1, 32'h20, 32'hAB, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_passthru: we=%b a=%h wd=%h stall=%b busy=%b want 1/20/ab/0/0",
                     mem_we, mem_a, mem_wd, cpu_stall, busy);
        end
        @(posedge clk);
        #1 cpu_we = 1'b0;
    endtask

    task automatic test_preload();
        cpu_write(32'h00, 32'd0);
        cpu_write(32'h04, 32'd0);
        cpu_write(32'h08, 32'd15);
        cpu_write(32'h0C, 32'd5);
        cpu_write(32'h10, 32'd50);
        cpu_write(32'h14, 32'd2);
        cpu_write(32'h18, 32'd100);
        cpu_a = 32'h10;
        @(negedge clk);
        checks++;
        if (cpu_rd !== 32'd50) begin
            failures++;
            $display("FAIL cpu_rd: got %h want %h", cpu_rd, 32'd50);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        int stall_cnt, done_cnt, done_at;
        logic finished;
        logic [31:0] wa, wd;
        stall_cnt = 0; done_cnt = 0; done_at = 0; finished = 1'b0;
        op_a = 32'd10; op_b = 32'd5; load_req = 1'b1;
        exp_wa.push_back(32'h0); exp_wd.push_back(32'd10);
        exp_wa.push_back(32'h4); exp_wd.push_back(32'd5);
        @(posedge clk);
        #1 load_req = 1'b0; op_a = 32'd99;
        cpu_we = 1'b1; cpu_a = 32'h18; cpu_wd = 32'hDEAD;
        for (int i = 1; i <= 12 && !finished; i++) begin
            @(negedge clk);
            if (cpu_stall) stall_cnt++;
            if (done) begin done_cnt++; done_at = i; end
            if (mem_we) begin
                checks++;
                if (exp_wa.size() == 0) begin
                    failures++;
                    $display("FAIL load_extra_write: a=%h wd=%h want no write", mem_a, mem_wd);
                end else begin
                    wa = exp_wa.pop_front(); wd = exp_wd.pop_front();
                    if ({mem_a, mem_wd} !== {wa, wd}) begin
                        failures++;
                        $display("FAIL load_write: got a=%h wd=%h want a=%h wd=%h", mem_a, mem_wd, wa, wd);
                    end
                end
            end
            if (i == 2) cpu_we = 1'b0;
            if (done_cnt > 0 && !busy) finished = 1'b1;
        end
        checks++;
        if (finished !== 1'b1) begin failures++; $display("FAIL load_timeout: finished=%b want 1", finished); end
        checks++;
        if (stall_cnt != 3) begin failures++; $display("FAIL load_stall: got %0d want 3", stall_cnt); end
        checks++;
        if (done_cnt != 1 || done_at != 3) begin
            failures++;
            $display("FAIL load_done: count %0d at %0d want 1 at 3", done_cnt, done_at);
        end
        checks++;
        if (exp_wa.size() != 0) begin failures++; $display("FAIL load_missing: %0d writes left want 0", exp_wa.size()); end
        checks++;
        if ({mem[0], mem[1]} !== {32'd10, 32'd5}) begin
            failures++;
            $display("FAIL load_mem: got %h %h want a 5", mem[0], mem[1]);
        end
        exp_wa.delete(); exp_wd.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_scan();
        int first_valid, last_valid, vcnt, done_at;
        logic finished;
        logic [2:0]  ei;
        logic [31:0] ed;
        first_valid = 0; last_valid = 0; vcnt = 0; done_at = 0; finished = 1'b0;
        push_scan_results();
        scan_req = 1'b1;
        @(posedge clk);
        #1 scan_req = 1'b0;
        for (int i = 1; i <= 15 && !finished; i++) begin
            @(negedge clk);
            if (res_valid) begin
                if (first_valid == 0) first_valid = i;
                last_valid = i;
                vcnt++;
                checks++;
                if (exp_idx.size() == 0) begin
                    failures++;
                    $display("FAIL scan_extra: idx=%0d data=%0d want none", res_idx, res_data);
                end else begin
                    ei = exp_idx.pop_front(); ed = exp_rd.pop_front();
                    if ({res_idx, res_data} !== {ei, ed}) begin
                        failures++;
                        $display("FAIL scan_result: got idx=%0d data=%0d want idx=%0d data=%0d", res_idx, res_data, ei, ed);
                    end
                end
            end
            if (mem_we) begin
                checks++; failures++;
                $display("FAIL scan_write: a=%h want no write", mem_a);
            end
            if (done) done_at = i;
            if (done_at != 0 && !busy) finished = 1'b1;
        end
        checks++;
        if (finished !== 1'b1) begin failures++; $display("FAIL scan_timeout: finished=%b want 1", finished); end
        checks++;
        if (first_valid != 2 || last_valid != 6 || vcnt != 5) begin
            failures++;
            $display("FAIL scan_window: first=%0d last=%0d cnt=%0d want 2 6 5", first_valid, last_valid, vcnt);
        end
        checks++;
        if (done_at != 6) begin failures++; $display("FAIL scan_done: at %0d want 6", done_at); end
        checks++;
        if ({res_valid, res_idx, res_data} !== {1'b0, 3'd4, 32'd100}) begin
            failures++;
            $display("FAIL scan_hold: valid=%b idx=%0d data=%0d want 0 4 100", res_valid, res_idx, res_data);
        end
        exp_idx.delete(); exp_rd.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_simultaneous();
        int done_at [3];
        int dcnt, first_valid;
        logic finished;
        logic [31:0] wa, wd, ed;
        logic [2:0]  ei;
        dcnt = 0; first_valid = 0; finished = 1'b0;
        done_at[0] = 0; done_at[1] = 0; done_at[2] = 0;
        op_a = 32'h1111_1111; op_b = 32'h2222_2222;
        exp_wa.push_back(32'h0); exp_wd.push_back(32'h0);
        exp_wa.push_back(32'h4); exp_wd.push_back(32'h0);
        exp_wa.push_back(32'h0); exp_wd.push_back(32'h1111_1111);
        exp_wa.push_back(32'h4); exp_wd.push_back(32'h2222_2222);
        push_scan_results();
        load_req = 1'b1; clear_req = 1'b1; scan_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0; clear_req = 1'b0; scan_req = 1'b0;
        for (int i = 1; i <= 40 && !finished; i++) begin
            @(negedge clk);
            if (mem_we) begin
                checks++;
                if (exp_wa.size() == 0) begin
                    failures++;
                    $display("FAIL simul_extra_write: a=%h wd=%h want none", mem_a, mem_wd);
                end else begin
                    wa = exp_wa.pop_front(); wd = exp_wd.pop_front();
                    if ({mem_a, mem_wd} !== {wa, wd}) begin
                        failures++;
                        $display("FAIL simul_write: got a=%h wd=%h want a=%h wd=%h", mem_a, mem_wd, wa, wd);
                    end
                end
            end
            if (res_valid) begin
                if (first_valid == 0) first_valid = i;
                checks++;
                if (exp_idx.size() == 0) begin
                    failures++;
                    $display("FAIL simul_extra_result: idx=%0d want none", res_idx);
                end else begin
                    ei = exp_idx.pop_front(); ed = exp_rd.pop_front();
                    if ({res_idx, res_data} !== {ei, ed}) begin
                        failures++;
                        $display("FAIL simul_result: got idx=%0d data=%0d want idx=%0d data=%0d", res_idx, res_data, ei, ed);
                    end
                end
            end
            if (done) begin
                if (dcnt < 3) done_at[dcnt] = i;
                dcnt++;
            end
            if (i == 4 || i == 8) begin
                checks++;
                if ({busy, cpu_stall} !== 2'b00) begin
                    failures++;
                    $display("FAIL simul_gap: cycle %0d busy=%b stall=%b want 0 0", i, busy, cpu_stall);
                end
            end
            if (dcnt >= 3 && !busy) finished = 1'b1;
        end
        checks++;
        if (finished !== 1'b1) begin failures++; $display("FAIL simul_timeout: finished=%b want 1", finished); end
        checks++;
        if (dcnt != 3 || done_at[0] != 3 || done_at[1] != 7 || done_at[2] != 14) begin
            failures++;
            $display("FAIL simul_done: cnt=%0d at %0d %0d %0d want 3 at 3 7 14", dcnt, done_at[0], done_at[1], done_at[2]);
        end
        checks++;
        if (first_valid != 10 || exp_wa.size() != 0 || exp_idx.size() != 0) begin
            failures++;
            $display("FAIL simul_order: first_valid=%0d writes_left=%0d results_left=%0d want 10 0 0",
                     first_valid, exp_wa.size(), exp_idx.size());
        end
        checks++;
        if ({mem[0], mem[1]} !== {32'h1111_1111, 32'h2222_2222}) begin
            failures++;
            $display("FAIL simul_mem: got %h %h want 11111111 22222222", mem[0], mem[1]);
        end
        exp_wa.delete(); exp_wd.delete(); exp_idx.delete(); exp_rd.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_absorb();
        int wcnt, dcnt;
        logic [31:0] wa, wd, ed;
        logic [2:0]  ei;
        wcnt = 0; dcnt = 0;
        op_a = 32'd7; op_b = 32'd8;
        exp_wa.push_back(32'h0); exp_wd.push_back(32'd7);
        exp_wa.push_back(32'h4); exp_wd.push_back(32'd8);
        push_scan_results();
        scan_req = 1'b1;
        @(posedge clk);
        #1 scan_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_we) begin
                wcnt++;
                checks++;
                if (exp_wa.size() == 0) begin
                    failures++;
                    $display("FAIL absorb_extra_write: a=%h wd=%h want none", mem_a, mem_wd);
                end else begin
                    wa = exp_wa.pop_front(); wd = exp_wd.pop_front();
                    if ({mem_a, mem_wd} !== {wa, wd}) begin
                        failures++;
                        $display("FAIL absorb_write: got a=%h wd=%h want a=%h wd=%h", mem_a, mem_wd, wa, wd);
                    end
                end
            end
            if (res_valid) begin
                checks++;
                if (exp_idx.size() == 0) begin
                    failures++;
                    $display("FAIL absorb_extra_result: idx=%0d want none", res_idx);
                end else begin
                    ei = exp_idx.pop_front(); ed = exp_rd.pop_front();
                    if ({res_idx, res_data} !== {ei, ed}) begin
                        failures++;
                        $display("FAIL absorb_result: got idx=%0d data=%0d want idx=%0d data=%0d", res_idx, res_data, ei, ed);
                    end
                end
            end
            if (done) dcnt++;
            if (i == 2 || i == 4) load_req = 1'b1;
            if (i == 3 || i == 5) load_req = 1'b0;
        end
        checks++;
        if (wcnt != 2 || dcnt != 2) begin
            failures++;
            $display("FAIL absorb_count: writes=%0d dones=%0d want 2 2", wcnt, dcnt);
        end
        checks++;
        if (exp_wa.size() != 0 || exp_idx.size() != 0) begin
            failures++;
            $display("FAIL absorb_missing: writes_left=%0d results_left=%0d want 0 0", exp_wa.size(), exp_idx.size());
        end
        checks++;
        if ({mem[0], mem[1]} !== {32'd7, 32'd8}) begin
            failures++;
            $display("FAIL absorb_mem: got %h %h want 7 8", mem[0], mem[1]);
        end
        exp_wa.delete(); exp_wd.delete(); exp_idx.delete(); exp_rd.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int busy_cnt, done_cnt, we_cnt;
        busy_cnt = 0; done_cnt = 0; we_cnt = 0;
        op_a = 32'hAAAA_AAAA; op_b = 32'hBBBB_BBBB;
        load_req = 1'b1; scan_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0; scan_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_a, mem_wd} !== {1'b1, 32'h0, 32'hAAAA_AAAA}) begin
            failures++;
            $display("FAIL rmid_lda: we=%b a=%h wd=%h want 1 0 aaaaaaaa", mem_we, mem_a, mem_wd);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_we, cpu_stall, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_async: we=%b stall=%b busy=%b done=%b want 0 0 0 0", mem_we, cpu_stall, busy, done);
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (mem_we) we_cnt++;
        end
        checks++;
        if (busy_cnt != 0 || done_cnt != 0 || we_cnt != 0) begin
            failures++;
            $display("FAIL rmid_after: busy=%0d done=%0d writes=%0d want 0 0 0", busy_cnt, done_cnt, we_cnt);
        end
        checks++;
        if ({mem[0], mem[1]} !== {32'd7, 32'd8}) begin
            failures++;
            $display("FAIL rmid_mem: got %h %h want 7 8", mem[0], mem[1]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_preload();
        test_load();
        test_scan();
        test_simultaneous();
        test_absorb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Owns the single write/read port of the data memory and shares it between the ARM core and the front-panel host sequencer.
- The host sequencer performs three operations: LOAD writes two operands to words 0/1, CLEAR zeroes words 0/1, and SCAN reads the five result words 2..6 one by one.
- While a host operation runs, the core is stalled and its memory access is blocked.
- Sits between the core's memory interface and the data memory.

Parameters:
- OPA_ADDR, 32'h0000_0000, byte address of operand A word
- OPB_ADDR, 32'h0000_0004, byte address of operand B word
- RES_BASE, 32'h0000_0008, byte address of first result word
- RES_COUNT, 5, number of result words scanned (1..7)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_req  in  1  single-cycle pulse: request LOAD
- clear_req  in  1  single-cycle pulse: request CLEAR
- scan_req  in  1  single-cycle pulse: request SCAN
- op_a  in  32  operand A value for LOAD
- op_b  in  32  operand B value for LOAD
- cpu_we  in  1  core write enable
- cpu_a  in  32  core byte address
- cpu_wd  in  32  core write data
- cpu_rd  out  32  read data to core (always mem_rd)
- cpu_stall  out  1  core must hold its PC and instruction
- mem_we  out  1  data memory write enable
- mem_a  out  32  data memory byte address
- mem_wd  out  32  data memory write data
- mem_rd  in  32  data memory combinational read data
- res_valid  out  1  registered; res_data/res_idx valid this cycle
- res_idx  out  3  registered; result index 0..RES_COUNT-1
- res_data  out  32  registered; captured result word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of a host operation

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; pending bits, operand registers and scan counter clear; res_valid, res_idx, res_data, done and busy are 0.
  - cpu_stall=0 and mem_we=0 are forced while reset_n is low.
  - Reset mid-operation aborts the operation immediately; no further host writes occur.
- Pending bits: pend_clr, pend_load and pend_scan are each set by their req on any edge and cleared when that operation is granted. A repeat request while pending is absorbed (no queue depth).
- IDLE:
  - Pure pass-through: mem_we=cpu_we, mem_a=cpu_a, mem_wd=cpu_wd, cpu_stall=0.
  - On an edge with any pending bit or req set, grant one operation with priority CLEAR > LOAD > SCAN.
  - A req in the same cycle counts as pending.
  - Granting LOAD captures op_a and op_b into internal registers on that same edge.
- States IDLE, CLR_A, CLR_B, LD_A, LD_B, SCAN, DONE. In every state except IDLE: cpu_stall=1, cpu_we is ignored, busy=1.
- CLR_A: mem_we=1, mem_a=OPA_ADDR, mem_wd=0; next state CLR_B.
- CLR_B: mem_we=1, mem_a=OPB_ADDR, mem_wd=0; next state DONE.
- LD_A: mem_we=1, mem_a=OPA_ADDR, mem_wd=captured A; next state LD_B.
- LD_B: same as LD_A with OPB_ADDR and captured B; next state DONE.
- SCAN:
  - mem_we=0, mem_a=RES_BASE+4*idx, where idx is a 3-bit counter starting at 0.
  - Each edge: res_data<=mem_rd, res_idx<=idx, res_valid<=1, idx++.
  - After idx=RES_COUNT-1, go to DONE and reset idx to 0.
- DONE: mem_we=0, done=1, cpu_stall=1; next state IDLE. A further pending op is granted only from IDLE, so the core gets at least one free cycle between host operations.
- res_valid is high exactly the cycle after each SCAN cycle (RES_COUNT consecutive cycles), otherwise 0. res_data and res_idx hold their last value when res_valid=0.
- Latencies from a req pulse sampled at edge k, with IDLE and nothing pending:
  - CLEAR/LOAD: writes in cycles k+1 and k+2; done in cycle k+3; IDLE at k+4.
  - SCAN: first res_valid in cycle k+2.
- A req arriving during a busy operation is serviced after that operation returns to IDLE. Requests are never dropped.
- cpu_rd = mem_rd at all times. Core reads during a stall are don't-care.

Test Plan:
- Reset check: after reset release with cpu_we=1, cpu_a=0x20, cpu_wd=0xAB -> mem_we=1, mem_a=0x20, mem_wd=0xAB, cpu_stall=0, busy=0.
- LOAD: op_a=10, op_b=5, pulse load_req, then change op_a to 99 next cycle.
  - Required: mem writes (0x0,10) then (0x4,5), cpu_stall high 3 cycles, done one cycle, and a core write issued during the stall never reaches mem_we.
- SCAN: memory words 2..6 = 15, 5, 50, 2, 100, pulse scan_req -> res_valid for 5 consecutive cycles with (idx, data) = (0,15), (1,5), (2,50), (3,2), (4,100), then done=1.
- Simultaneous load_req, clear_req and scan_req in one cycle -> sequence is CLEAR, then LOAD, then SCAN, each followed by DONE and one IDLE cycle; memory words 0/1 end as op_a/op_b.
- load_req pulsed twice during an active SCAN -> exactly one LOAD is performed after the SCAN completes.
- reset_n asserted during LD_A -> mem_we=0 and cpu_stall=0 immediately; word 1 is never written; no done pulse; all pending bits are clear after release.
